// File: rtl/axi_riscv_excl_pkg.sv
// Shared definitions for the exclusive-access filter in front of the LR/SC adapter.
// Holds the default AXI channel/request/response structs, the FSM state enums,
// the SLVERR response code and the illegal-exclusive check.
package axi_riscv_excl_pkg;

  // Same encoding as axi_pkg::RESP_SLVERR.
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Default bus geometry; the req/resp structs below are built for it.
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_ID_W   = 4;
  localparam int unsigned DEF_USER_W = 1;

  typedef enum logic       {RD_IDLE, RD_ERR} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DRAIN, WR_ERR} wr_state_e;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [DEF_USER_W-1:0] user;
  } ax_chan_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_DATA_W/8-1:0] strb;
    logic                    last;
    logic [DEF_USER_W-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [DEF_USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [DEF_USER_W-1:0] user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

  // An exclusive the adapter cannot track: bursts (this also covers FIXED
  // bursts with len > 0), accesses wider than the bus, or unaligned accesses.
  function automatic logic excl_illegal(input logic [7:0] addr_lsb,
                                        input logic [7:0] len,
                                        input logic [2:0] size,
                                        input logic       lock,
                                        input int         strb_w);
    logic [7:0] mask;
    mask = (8'd1 << size) - 8'd1;
    return lock && ((len != 8'd0) || (int'(size) > $clog2(strb_w)) ||
                    ((addr_lsb & mask) != 8'd0));
  endfunction

endpackage

// File: rtl/axi_riscv_excl_cnt.sv
// Saturating up/down counter of outstanding transactions.
// Ports: clk_i/rst_i clock and async active-high reset; inc/dec step requests;
// full when the count equals MAX, empty when it is zero.
module axi_riscv_excl_cnt #(
  parameter int unsigned MAX = 4,
  localparam int unsigned W = $clog2(MAX + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [W-1:0] cnt;
  logic         inc_ok, dec_ok;

  assign full   = (cnt == W'(MAX));
  assign empty  = (cnt == '0);
  assign inc_ok = inc && !full;
  assign dec_ok = dec && !empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 cnt <= '0;
    else if (inc_ok && !dec_ok) cnt <= cnt + W'(1);
    else if (dec_ok && !inc_ok) cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/axi_riscv_excl_filter.sv
// Exclusive-access filter in front of the LR/SC adapter.
// Legal traffic passes combinationally (zero latency), gated only by the
// outstanding-transaction counters. Untrackable exclusives (bursts, oversize,
// misaligned) are answered locally with SLVERR once all earlier forwarded
// transactions on that channel have completed, so per-ID order is kept.
// Ports: clk_i/rst_i clock and async active-high reset; slv_req_i/slv_resp_o
// core-side AXI port; mst_req_o/mst_resp_i port toward the adapter.
module axi_riscv_excl_filter
  import axi_riscv_excl_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH     = DEF_ADDR_W,
  parameter int unsigned AXI_DATA_WIDTH     = DEF_DATA_W,
  parameter int unsigned AXI_ID_WIDTH       = DEF_ID_W,
  parameter int unsigned AXI_USER_WIDTH     = DEF_USER_W,
  parameter int unsigned AXI_MAX_READ_TXNS  = 4,
  parameter int unsigned AXI_MAX_WRITE_TXNS = 4,
  parameter type         req_t              = axi_req_t,
  parameter type         resp_t             = axi_resp_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i
);

  localparam int STRB_W = int'(AXI_DATA_WIDTH / 8);

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;

  logic [AXI_ID_WIDTH-1:0]   rd_id_q, wr_id_q;
  logic [AXI_USER_WIDTH-1:0] rd_user_q, wr_user_q;
  logic [8:0]                beats_q, beats_d;
  logic                      rd_lat, wr_lat;
  logic                      ar_bad, aw_bad;
  logic                      rd_full, rd_empty, wr_full, wr_empty;
  logic                      rd_inc, rd_dec, wr_inc, wr_dec;

  // Head requests that must be terminated locally.
  assign ar_bad = slv_req_i.ar_valid &&
                  excl_illegal(slv_req_i.ar.addr[7:0], slv_req_i.ar.len,
                               slv_req_i.ar.size, slv_req_i.ar.lock, STRB_W);
  assign aw_bad = slv_req_i.aw_valid &&
                  excl_illegal(slv_req_i.aw.addr[7:0], slv_req_i.aw.len,
                               slv_req_i.aw.size, slv_req_i.aw.lock, STRB_W);

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    rd_state_d = rd_state_q;
    wr_state_d = wr_state_q;
    beats_d    = beats_q;
    rd_lat     = 1'b0;
    wr_lat     = 1'b0;

    // ---------------- read side ----------------
    mst_req_o.ar_valid  = 1'b0;
    slv_resp_o.ar_ready = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_bad) begin
          // Wait for all forwarded reads to finish before answering.
          slv_resp_o.ar_ready = rd_empty;
          if (rd_empty) begin
            rd_lat     = 1'b1;
            rd_state_d = RD_ERR;
          end
        end else if (!rd_full) begin
          mst_req_o.ar_valid  = slv_req_i.ar_valid;
          slv_resp_o.ar_ready = mst_resp_i.ar_ready;
        end
      end
      RD_ERR: begin
        // rd_cnt is zero here, so the adapter has no R beats to deliver.
        mst_req_o.r_ready  = 1'b0;
        slv_resp_o.r_valid = 1'b1;
        slv_resp_o.r       = '0;
        slv_resp_o.r.id    = rd_id_q;
        slv_resp_o.r.user  = rd_user_q;
        slv_resp_o.r.resp  = RESP_SLVERR;
        slv_resp_o.r.last  = 1'b1;
        if (slv_req_i.r_ready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase

    // ---------------- write side ----------------
    mst_req_o.aw_valid  = 1'b0;
    slv_resp_o.aw_ready = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_bad) begin
          // W data behind an illegal head belongs to it; keep it upstream.
          mst_req_o.w_valid   = 1'b0;
          slv_resp_o.w_ready  = 1'b0;
          slv_resp_o.aw_ready = wr_empty;
          if (wr_empty) begin
            wr_lat     = 1'b1;
            beats_d    = {1'b0, slv_req_i.aw.len} + 9'd1;
            wr_state_d = WR_DRAIN;
          end
        end else if (!wr_full) begin
          mst_req_o.aw_valid  = slv_req_i.aw_valid;
          slv_resp_o.aw_ready = mst_resp_i.aw_ready;
        end
      end
      WR_DRAIN: begin
        mst_req_o.w_valid  = 1'b0;
        slv_resp_o.w_ready = 1'b1;
        if (slv_req_i.w_valid) begin
          beats_d = beats_q - 9'd1;
          if (slv_req_i.w.last) wr_state_d = WR_ERR;
        end
      end
      WR_ERR: begin
        mst_req_o.w_valid  = 1'b0;
        slv_resp_o.w_ready = 1'b0;
        mst_req_o.b_ready  = 1'b0;
        slv_resp_o.b_valid = 1'b1;
        slv_resp_o.b       = '0;
        slv_resp_o.b.id    = wr_id_q;
        slv_resp_o.b.user  = wr_user_q;
        slv_resp_o.b.resp  = RESP_SLVERR;
        if (slv_req_i.b_ready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase

    // While reset is held nothing may handshake on either side.
    if (rst_i) begin
      mst_req_o.aw_valid  = 1'b0;
      mst_req_o.w_valid   = 1'b0;
      mst_req_o.ar_valid  = 1'b0;
      mst_req_o.b_ready   = 1'b0;
      mst_req_o.r_ready   = 1'b0;
      slv_resp_o.aw_ready = 1'b0;
      slv_resp_o.w_ready  = 1'b0;
      slv_resp_o.ar_ready = 1'b0;
      slv_resp_o.b_valid  = 1'b0;
      slv_resp_o.r_valid  = 1'b0;
    end
  end

  assign rd_inc = mst_req_o.ar_valid && mst_resp_i.ar_ready;
  assign rd_dec = mst_resp_i.r_valid && mst_req_o.r_ready && mst_resp_i.r.last;
  assign wr_inc = mst_req_o.aw_valid && mst_resp_i.aw_ready;
  assign wr_dec = mst_resp_i.b_valid && mst_req_o.b_ready;

  axi_riscv_excl_cnt #(.MAX(AXI_MAX_READ_TXNS)) i_rd_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (rd_inc),
    .dec   (rd_dec),
    .full  (rd_full),
    .empty (rd_empty)
  );

  axi_riscv_excl_cnt #(.MAX(AXI_MAX_WRITE_TXNS)) i_wr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (wr_inc),
    .dec   (wr_dec),
    .full  (wr_full),
    .empty (wr_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_id_q    <= '0;
      rd_user_q  <= '0;
      wr_id_q    <= '0;
      wr_user_q  <= '0;
      beats_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      beats_q    <= beats_d;
      if (rd_lat) begin
        rd_id_q   <= slv_req_i.ar.id;
        rd_user_q <= slv_req_i.ar.user;
      end
      if (wr_lat) begin
        wr_id_q   <= slv_req_i.aw.id;
        wr_user_q <= slv_req_i.aw.user;
      end
    end
  end

`ifndef SYNTHESIS
  // The final drained beat should match the AW length.
  drain_len_match: assert property (@(posedge clk_i) disable iff (rst_i)
    (wr_state_q == WR_DRAIN && slv_req_i.w_valid && slv_req_i.w.last) |-> beats_q == 9'd1);
`endif

endmodule

// File: tb/tb_axi_riscv_excl_filter.sv
module tb_axi_riscv_excl_filter;
  import axi_riscv_excl_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  axi_req_t  slv_req, mst_req;
  axi_resp_t slv_resp, mst_resp;
  int        checks = 0;
  int        failures = 0;

  always #5 clk = ~clk;

  axi_riscv_excl_filter #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1),
    .AXI_MAX_READ_TXNS(2), .AXI_MAX_WRITE_TXNS(2),
    .req_t(axi_req_t), .resp_t(axi_resp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    slv_req = '0;
    mst_resp = '0;
  endtask

  task automatic set_ax(output ax_chan_t ax, input logic lock, input logic [7:0] len,
                        input logic [2:0] size, input logic [31:0] addr, input logic [3:0] id);
    ax = '0;
    ax.lock = lock; ax.len = len; ax.size = size; ax.addr = addr; ax.id = id;
    ax.burst = 2'b01;
  endtask

  typedef struct {
    logic        lock;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [31:0] addr;
    logic        fwd;   // expected: forwarded to adapter / W passes
  } vec_t;

  vec_t vecs[9];
  ax_chan_t ax;
  logic bad;

  initial begin
    vecs[0] = '{1'b1, 8'd0, 3'd3, 32'h1000, 1'b1};
    vecs[1] = '{1'b1, 8'd3, 3'd3, 32'h1000, 1'b0};
    vecs[2] = '{1'b1, 8'd0, 3'd4, 32'h1000, 1'b0};
    vecs[3] = '{1'b1, 8'd0, 3'd2, 32'h1002, 1'b0};
    vecs[4] = '{1'b1, 8'd0, 3'd2, 32'h1004, 1'b1};
    vecs[5] = '{1'b0, 8'd7, 3'd4, 32'h1003, 1'b1};
    vecs[6] = '{1'b1, 8'd0, 3'd0, 32'h1007, 1'b1};
    vecs[7] = '{1'b1, 8'd0, 3'd1, 32'h1001, 1'b0};
    vecs[8] = '{1'b1, 8'd0, 3'd3, 32'h1004, 1'b0};

    // Reset state, with upstream valids and downstream readys asserted.
    idle_bus();
    slv_req.ar_valid = 1'b1; slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1;
    mst_resp.ar_ready = 1'b1; mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    mst_resp.r_valid = 1'b1; mst_resp.b_valid = 1'b1;
    #2;
    chk("rst_mst_valids", {mst_req.ar_valid, mst_req.aw_valid, mst_req.w_valid}, 3'b000);
    chk("rst_slv_readys", {slv_resp.ar_ready, slv_resp.aw_ready, slv_resp.w_ready}, 3'b000);
    chk("rst_slv_valids", {slv_resp.r_valid, slv_resp.b_valid}, 2'b00);
    @(negedge clk); idle_bus(); rst = 1'b0;
    @(negedge clk);

    // Combinational legality table: no clock edge sees a valid.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      idle_bus();
      mst_resp.ar_ready = 1'b1; mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
      set_ax(ax, vecs[i].lock, vecs[i].len, vecs[i].size, vecs[i].addr, 4'd1);
      slv_req.ar = ax; slv_req.aw = ax;
      slv_req.ar_valid = 1'b1; slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1;
      #1;
      chk($sformatf("tbl%0d_ar_fwd", i), mst_req.ar_valid, vecs[i].fwd);
      chk($sformatf("tbl%0d_aw_fwd", i), mst_req.aw_valid, vecs[i].fwd);
      chk($sformatf("tbl%0d_w_pass", i), slv_resp.w_ready, vecs[i].fwd);
      idle_bus();
    end

    // 1. Legal LR forwarded same cycle, R returned unchanged.
    @(negedge clk);
    idle_bus(); mst_resp.ar_ready = 1'b1;
    set_ax(ax, 1'b1, 8'd0, 3'd3, 32'h1000, 4'd5); slv_req.ar = ax; slv_req.ar_valid = 1'b1;
    #1;
    chk("lr_ar_fwd", {mst_req.ar_valid, slv_resp.ar_ready}, 2'b11);
    chk("lr_ar_id", mst_req.ar.id, 4'd5);
    chk("lr_ar_addr", mst_req.ar.addr, 32'h1000);
    @(negedge clk);
    idle_bus();
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 4'd5; mst_resp.r.data = 64'hDEAD_BEEF_0123_4567;
    mst_resp.r.last = 1'b1; slv_req.r_ready = 1'b1;
    #1;
    chk("lr_r_valid", {slv_resp.r_valid, mst_req.r_ready}, 2'b11);
    chk("lr_r_id", slv_resp.r.id, 4'd5);
    chk("lr_r_data", slv_resp.r.data, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk); idle_bus();

    // 4. Misaligned LR terminated locally.
    @(negedge clk);
    mst_resp.ar_ready = 1'b1;
    set_ax(ax, 1'b1, 8'd0, 3'd2, 32'h1002, 4'd3); slv_req.ar = ax; slv_req.ar_valid = 1'b1;
    #1;
    chk("mis_ar_blocked", {mst_req.ar_valid, slv_resp.ar_ready}, 2'b01);
    @(negedge clk);
    slv_req.ar_valid = 1'b0;
    #1;
    chk("mis_r_valid", slv_resp.r_valid, 1'b1);
    chk("mis_r_fields", {slv_resp.r.id, slv_resp.r.resp, slv_resp.r.last}, {4'd3, 2'b10, 1'b1});
    chk("mis_r_data", slv_resp.r.data, 64'd0);
    chk("mis_no_mst_ar", mst_req.ar_valid, 1'b0);
    slv_req.r_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("mis_r_done", slv_resp.r_valid, 1'b0);
    idle_bus();

    // 5. Read saturation at two outstanding.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_bus(); mst_resp.ar_ready = 1'b1;
      set_ax(ax, 1'b0, 8'd0, 3'd3, 32'h2000, 4'(i)); slv_req.ar = ax; slv_req.ar_valid = 1'b1;
      #1;
      chk($sformatf("sat_ar%0d_ready", i), slv_resp.ar_ready, (i < 2) ? 1'b1 : 1'b0);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (slv_resp.ar_ready || mst_req.ar_valid) bad = 1'b1;
    end
    chk("sat_stall_held", bad, 1'b0);
    @(negedge clk);
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1; slv_req.r_ready = 1'b1;
    #1;
    chk("sat_ready_before_dec", slv_resp.ar_ready, 1'b0);
    @(negedge clk);
    mst_resp.r_valid = 1'b0;
    #1;
    chk("sat_ready_after_dec", {slv_resp.ar_ready, mst_req.ar_valid}, 2'b11);
    @(negedge clk);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
    @(negedge clk); @(negedge clk);
    idle_bus();

    // 2. Burst SC drained and answered with SLVERR.
    @(negedge clk);
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    set_ax(ax, 1'b1, 8'd3, 3'd3, 32'h3000, 4'd2); slv_req.aw = ax; slv_req.aw_valid = 1'b1;
    #1;
    chk("sc_aw_blocked", {mst_req.aw_valid, slv_resp.aw_ready}, 2'b01);
    @(negedge clk);
    slv_req.aw_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      slv_req.w_valid = 1'b1; slv_req.w.last = (i == 3); slv_req.w.data = 64'(i);
      #1;
      if (!slv_resp.w_ready || mst_req.w_valid || slv_resp.b_valid) bad = 1'b1;
    end
    chk("sc_w_drained", bad, 1'b0);
    @(negedge clk);
    slv_req.w_valid = 1'b0;
    #1;
    chk("sc_b_valid", slv_resp.b_valid, 1'b1);
    chk("sc_b_fields", {slv_resp.b.id, slv_resp.b.resp}, {4'd2, 2'b10});
    chk("sc_no_mst_aw", mst_req.aw_valid, 1'b0);
    slv_req.b_ready = 1'b1;
    @(negedge clk); #1;
    chk("sc_b_done", slv_resp.b_valid, 1'b0);
    idle_bus();

    // 3. Ordering: legal B must come out before the local SLVERR B.
    @(negedge clk);
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    set_ax(ax, 1'b0, 8'd0, 3'd3, 32'h4000, 4'd1); slv_req.aw = ax; slv_req.aw_valid = 1'b1;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
    #1;
    chk("ord_legal_fwd", {mst_req.aw_valid, mst_req.w_valid}, 2'b11);
    @(negedge clk);
    slv_req.w_valid = 1'b0;
    set_ax(ax, 1'b1, 8'd0, 3'd4, 32'h4000, 4'd1); slv_req.aw = ax; slv_req.b_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (slv_resp.aw_ready || slv_resp.b_valid || mst_req.aw_valid) bad = 1'b1;
    end
    chk("ord_illegal_held", bad, 1'b0);
    @(negedge clk);
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd1; mst_resp.b.resp = 2'b00;
    #1;
    chk("ord_legal_b_first", {slv_resp.b_valid, slv_resp.b.id, slv_resp.b.resp}, {1'b1, 4'd1, 2'b00});
    chk("ord_still_held", slv_resp.aw_ready, 1'b0);
    @(negedge clk);
    mst_resp.b_valid = 1'b0;
    #1;
    chk("ord_illegal_accept", slv_resp.aw_ready, 1'b1);
    @(negedge clk);
    slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
    bad = 1'b1;
    for (int i = 0; i < 10 && bad; i++) begin
      @(negedge clk);
      slv_req.w_valid = 1'b0;
      #1;
      if (slv_resp.b_valid) bad = 1'b0;
    end
    chk("ord_err_b_seen", bad, 1'b0);
    chk("ord_err_b_fields", {slv_resp.b.id, slv_resp.b.resp}, {4'd1, 2'b10});
    @(negedge clk); idle_bus();

    // 6. Reset in the middle of a drain.
    @(negedge clk);
    set_ax(ax, 1'b1, 8'd3, 3'd3, 32'h5000, 4'd4); slv_req.aw = ax; slv_req.aw_valid = 1'b1;
    @(negedge clk);
    slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b1;
    @(negedge clk);
    mst_resp.ar_ready = 1'b1; mst_resp.r_valid = 1'b1; mst_resp.b_valid = 1'b1;
    set_ax(ax, 1'b0, 8'd0, 3'd3, 32'h6000, 4'd6); slv_req.ar = ax; slv_req.ar_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst2_slv_readys", {slv_resp.w_ready, slv_resp.aw_ready, slv_resp.ar_ready}, 3'b000);
    chk("rst2_valids", {mst_req.ar_valid, slv_resp.r_valid, slv_resp.b_valid}, 3'b000);
    @(negedge clk);
    idle_bus(); rst = 1'b0;
    @(negedge clk);
    mst_resp.ar_ready = 1'b1; mst_resp.aw_ready = 1'b1;
    set_ax(ax, 1'b0, 8'd0, 3'd3, 32'h6000, 4'd6);
    slv_req.ar = ax; slv_req.aw = ax; slv_req.ar_valid = 1'b1; slv_req.aw_valid = 1'b1;
    #1;
    chk("post_rst_legal_fwd", {mst_req.ar_valid, mst_req.aw_valid}, 2'b11);
    set_ax(ax, 1'b1, 8'd1, 3'd3, 32'h6000, 4'd6);
    slv_req.ar = ax; slv_req.aw = ax;
    #1;
    chk("post_rst_cnt_zero", {slv_resp.ar_ready, slv_resp.aw_ready, mst_req.ar_valid}, 3'b110);
    idle_bus();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
